// File: rtl/bus_arbiter_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_arbiter_n                                                |
// | Description : N-master to single-slave bus arbiter with registered grant,  |
// |               fixed or round-robin priority and slave wait-timeout.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bus_arbiter_n #(
   parameter int NUM_MASTERS = 2,
   parameter int AW          = 16,
   parameter int DW          = 8,
   parameter int ROUND_ROBIN = 0,
   parameter int TIMEOUT     = 255,
   localparam int IW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [NUM_MASTERS-1:0]    i_m_cs,
   input  logic [NUM_MASTERS-1:0]    i_m_we,
   input  logic [NUM_MASTERS*AW-1:0] i_m_addr,
   input  logic [NUM_MASTERS*DW-1:0] i_m_dat,
   output logic [NUM_MASTERS-1:0]    o_m_ack,
   output logic [NUM_MASTERS-1:0]    o_m_err,
   output logic [NUM_MASTERS-1:0]    o_m_grant,
   output logic [IW-1:0]             o_grant_id,
   output logic                      o_busy,
   output logic [AW-1:0]             o_addr,
   output logic [DW-1:0]             o_dat,
   output logic                      o_we,
   output logic                      o_cs,
   input  logic                      i_ack
);

   localparam int c_cw   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int c_tlim = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
   localparam logic [c_cw-1:0] c_tlim_v   = c_cw'(c_tlim);
   localparam logic [c_cw-1:0] c_cnt_max  = {c_cw{1'b1}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_TOUT = 2'd2;

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [IW-1:0]          r_gid;
   logic [c_cw-1:0]        r_cnt;

   logic [IW-1:0]          w_win;
   logic [NUM_MASTERS-1:0] w_win_oh;
   logic                   w_any_req;
   logic                   w_grant_load;
   logic                   w_tout_hit;
   logic                   w_g_cs;
   logic                   w_g_we;
   logic [AW-1:0]          w_g_addr;
   logic [DW-1:0]          w_g_dat;

   assign w_any_req    = |i_m_cs;
   assign w_grant_load = (r_state == S_IDLE) && w_any_req;

   assign w_g_cs   = i_m_cs[r_gid];
   assign w_g_we   = i_m_we[r_gid];
   assign w_g_addr = i_m_addr[int'(r_gid) * AW +: AW];
   assign w_g_dat  = i_m_dat[int'(r_gid) * DW +: DW];

   // An acknowledge arriving on the last permitted wait cycle still wins.
   assign w_tout_hit = (TIMEOUT != 0) && !i_ack && (r_cnt == c_tlim_v);

   generate
      if (ROUND_ROBIN != 0) begin : g_rr
         logic [IW-1:0] r_rr;
         logic [IW-1:0] w_idx;
         logic          w_found;

         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_rr <= IW'(NUM_MASTERS - 1);
            end else if (w_grant_load) begin
               r_rr <= w_win;
            end
         end

         // Search starts just after the last winner and wraps once around.
         always_comb begin
            w_win   = '0;
            w_idx   = '0;
            w_found = 1'b0;
            for (int j = 1; j <= NUM_MASTERS; j++) begin
               w_idx = IW'((int'(r_rr) + j) % NUM_MASTERS);
               if (!w_found && i_m_cs[w_idx]) begin
                  w_found = 1'b1;
                  w_win   = w_idx;
               end
            end
         end
      end else begin : g_fixed
         logic w_found;

         always_comb begin
            w_win   = '0;
            w_found = 1'b0;
            for (int k = 0; k < NUM_MASTERS; k++) begin
               if (!w_found && i_m_cs[k]) begin
                  w_found = 1'b1;
                  w_win   = IW'(k);
               end
            end
         end
      end
   endgenerate

   always_comb begin
      w_win_oh        = '0;
      w_win_oh[w_win] = 1'b1;
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!w_g_cs) begin
               w_state_nxt = S_IDLE;
            end else if (w_tout_hit) begin
               w_state_nxt = S_TOUT;
            end
         end
         S_TOUT: begin
            if (!w_g_cs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Grant, grant id and wait counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_grant <= '0;
         r_gid   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant <= w_win_oh;
                  r_gid   <= w_win;
                  r_cnt   <= '0;
               end
            end
            S_BUSY: begin
               if (!w_g_cs) begin
                  r_grant <= '0;
                  r_gid   <= '0;
               end else if (i_ack) begin
                  r_cnt <= '0;
               end else if (r_cnt != c_cnt_max) begin
                  r_cnt <= r_cnt + c_cw'(1);
               end
            end
            S_TOUT: begin
               if (!w_g_cs) begin
                  r_grant <= '0;
                  r_gid   <= '0;
               end
            end
            default: begin
               r_grant <= '0;
               r_gid   <= '0;
            end
         endcase
      end
   end

   // Output logic; the slave side and acks are silenced while reset is held
   always_comb begin
      o_m_ack = '0;
      o_m_err = '0;
      o_cs    = 1'b0;
      o_we    = 1'b0;
      o_addr  = '0;
      o_dat   = '0;
      if (!i_reset) begin
         case (r_state)
            S_BUSY: begin
               o_addr         = w_g_addr;
               o_dat          = w_g_dat;
               o_we           = w_g_we;
               o_cs           = w_g_cs;
               o_m_ack[r_gid] = i_ack & w_g_cs;
            end
            S_TOUT: begin
               o_addr         = w_g_addr;
               o_dat          = w_g_dat;
               o_m_ack[r_gid] = w_g_cs;
               o_m_err[r_gid] = w_g_cs;
            end
            default: ;
         endcase
      end
   end

   assign o_m_grant  = r_grant;
   assign o_grant_id = r_gid;
   assign o_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bus_arbiter_n                                             |
// | Description : Scoreboard bench; fixed/timeout and round-robin/no-timeout   |
// |               arbiters share random master traffic against a ref model.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bus_arbiter_n;

   localparam int C_N      = 3;
   localparam int C_CYCLES = 2600;
   localparam int C_RR [2] = '{0, 1};
   localparam int C_TO [2] = '{4, 0};

   typedef struct packed {
      logic [2:0]  ack;
      logic [2:0]  err;
      logic [2:0]  grant;
      logic [1:0]  gid;
      logic        busy;
      logic        cs;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  cs;
   logic [2:0]  we;
   logic [47:0] addr;
   logic [23:0] dat;
   logic        ack;

   logic [2:0]  f_ack, f_err, f_grant, r_ack, r_err, r_grant;
   logic [1:0]  f_gid, r_gid;
   logic        f_busy, f_we, f_cs, r_busy, r_we, r_cs;
   logic [15:0] f_addr, r_addr;
   logic [7:0]  f_dat, r_dat;

   exp_t q_f[$];
   exp_t q_r[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   bit   started  = 1'b0;

   // reference model state, per arbiter instance
   int   owner [2];
   bit   tout  [2];
   int   waits [2];
   int   ptr   [2];

   always #5 clk = ~clk;

   bus_arbiter_n #(.NUM_MASTERS(3), .AW(16), .DW(8), .ROUND_ROBIN(0), .TIMEOUT(4)) dut_f (
      .i_clk(clk), .i_reset(rst), .i_m_cs(cs), .i_m_we(we), .i_m_addr(addr), .i_m_dat(dat),
      .o_m_ack(f_ack), .o_m_err(f_err), .o_m_grant(f_grant), .o_grant_id(f_gid),
      .o_busy(f_busy), .o_addr(f_addr), .o_dat(f_dat), .o_we(f_we), .o_cs(f_cs), .i_ack(ack)
   );

   bus_arbiter_n #(.NUM_MASTERS(3), .AW(16), .DW(8), .ROUND_ROBIN(1), .TIMEOUT(0)) dut_r (
      .i_clk(clk), .i_reset(rst), .i_m_cs(cs), .i_m_we(we), .i_m_addr(addr), .i_m_dat(dat),
      .o_m_ack(r_ack), .o_m_err(r_err), .o_m_grant(r_grant), .o_grant_id(r_gid),
      .o_busy(r_busy), .o_addr(r_addr), .o_dat(r_dat), .o_we(r_we), .o_cs(r_cs), .i_ack(ack)
   );

   task automatic chk(input string dn, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s at %0t: got %h expected %h", dn, fld, $time, act, exp);
      end
   endtask

   task automatic check_out(input string dn, input exp_t e, input exp_t a);
      chk(dn, "m_ack",    32'(a.ack),   32'(e.ack));
      chk(dn, "m_err",    32'(a.err),   32'(e.err));
      chk(dn, "m_grant",  32'(a.grant), 32'(e.grant));
      chk(dn, "grant_id", 32'(a.gid),   32'(e.gid));
      chk(dn, "busy",     32'(a.busy),  32'(e.busy));
      chk(dn, "cs",       32'(a.cs),    32'(e.cs));
      chk(dn, "we",       32'(a.we),    32'(e.we));
      chk(dn, "addr",     32'(a.addr),  32'(e.addr));
      chk(dn, "dat",      32'(a.dat),   32'(e.dat));
   endtask

   function automatic exp_t act_f();
      exp_t a;
      a = {f_ack, f_err, f_grant, f_gid, f_busy, f_cs, f_we, f_addr, f_dat};
      return a;
   endfunction

   function automatic exp_t act_r();
      exp_t a;
      a = {r_ack, r_err, r_grant, r_gid, r_busy, r_cs, r_we, r_addr, r_dat};
      return a;
   endfunction

   // Expected visible outputs for the current cycle from model state and live inputs
   function automatic exp_t model_out(input int d);
      exp_t e;
      int   g;
      e = '0;
      g = owner[d];
      if (g >= 0) begin
         e.grant[g] = 1'b1;
         e.gid      = 2'(g);
         e.busy     = 1'b1;
         if (!rst) begin
            e.addr = addr[g*16 +: 16];
            e.dat  = dat[g*8 +: 8];
            if (!tout[d]) begin
               e.cs     = cs[g];
               e.we     = we[g];
               e.ack[g] = ack & cs[g];
            end else begin
               e.ack[g] = cs[g];
               e.err[g] = cs[g];
            end
         end
      end
      return e;
   endfunction

   // Advance one clock edge using the inputs present during the elapsed cycle
   task automatic model_step(input int d);
      int g;
      int w;
      int k;
      if (rst) begin
         owner[d] = -1; tout[d] = 1'b0; waits[d] = 0; ptr[d] = C_N - 1;
      end else if (owner[d] < 0) begin
         if (cs != 3'b000) begin
            w = -1;
            if (C_RR[d] == 0) begin
               for (int i = 0; i < C_N; i++) if (w < 0 && cs[i]) w = i;
            end else begin
               for (int j = 1; j <= C_N; j++) begin
                  k = (ptr[d] + j) % C_N;
                  if (w < 0 && cs[k]) w = k;
               end
               ptr[d] = w;
            end
            owner[d] = w; waits[d] = 0; tout[d] = 1'b0;
         end
      end else begin
         g = owner[d];
         if (!cs[g]) begin
            owner[d] = -1; tout[d] = 1'b0;
         end else if (!tout[d]) begin
            if (ack) waits[d] = 0;
            else if (C_TO[d] != 0 && waits[d] == C_TO[d] - 1) tout[d] = 1'b1;
            else waits[d]++;
         end
      end
   endtask

   // Monitor: pops one expected record per arbiter each cycle and compares
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (started) begin
            if (q_f.size() == 0) begin
               n_assert++; n_fail++;
               $display("FAIL dut_f.queue at %0t: got empty expected entry", $time);
            end else begin
               e = q_f.pop_front();
               check_out("dut_f", e, act_f());
            end
            if (q_r.size() == 0) begin
               n_assert++; n_fail++;
               $display("FAIL dut_r.queue at %0t: got empty expected entry", $time);
            end else begin
               e = q_r.pop_front();
               check_out("dut_r", e, act_r());
            end
         end
      end
   end

   // Stimulus
   initial begin
      int ack_pct;
      rst = 1'b1; cs = '0; we = '0; addr = '0; dat = '0; ack = 1'b0;
      ack_pct = 50;
      for (int d = 0; d < 2; d++) begin
         owner[d] = -1; tout[d] = 1'b0; waits[d] = 0; ptr[d] = C_N - 1;
      end
      repeat (2) @(posedge clk);
      for (int cyc = 0; cyc < C_CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         model_step(0);
         model_step(1);

         if (cyc % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       ack_pct = 10;
               1:       ack_pct = 50;
               default: ack_pct = 90;
            endcase
         end
         if (cyc >= 1800) ack_pct = 70;

         rst = (cyc < 3) || ($urandom_range(0, 99) == 0);
         for (int k = 0; k < C_N; k++) begin
            if (cs[k]) cs[k] = ($urandom_range(0, 99) >= 15);
            else       cs[k] = ($urandom_range(0, 99) < 25);
         end
         ack = ($urandom_range(0, 99) < ack_pct);

         // Long hung-slave window: master 1 holds its request with no slave ack
         if (cyc >= 1500 && cyc < 1800) begin
            rst   = 1'b0;
            ack   = 1'b0;
            cs[1] = 1'b1;
         end

         we   = 3'($urandom);
         addr = {16'($urandom), 16'($urandom), 16'($urandom)};
         dat  = 24'($urandom);

         q_f.push_back(model_out(0));
         q_r.push_back(model_out(1));
         started = 1'b1;
      end
      @(negedge clk);
      #1;
      chk("dut_f", "q_left", 32'(q_f.size()), 32'd0);
      chk("dut_r", "q_left", 32'(q_r.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
